sensor_responder: RTL
=====================

Name: sensor_responder

Overview:
- Sensor-side UART protocol responder, downstream of the polling arbitrator on the serial link.
- Watches received select bytes and acts only on bytes carrying its own sensor ID.
- On a match it captures one 8-bit sensor sample, computes a bit-serial CRC-8 over it, and transmits a 2-byte reply: data byte, then CRC byte.
- A pending alarm replaces the normal reply with an alarm frame that the arbitrator's CRC checker recognises.

Parameters:
- SENSOR_ID, 3'd1: this node's address; valid range 1..5.
- ALARM_CODE, 8'hAA: data byte sent in an alarm frame.
- CRC_POLY, 8'h07: CRC-8 polynomial, x^8+x^2+x+1; init 8'h00; MSB first; no reflection.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- rx_dout  in  8  byte from the UART receiver.
- rx_rdy  in  1  UART receiver has a byte; level, held until cleared.
- rx_rdy_clr  out  1  one-cycle pulse that clears rx_rdy.
- tx_din  out  8  byte to the UART transmitter.
- tx_wr_en  out  1  one-cycle pulse that loads tx_din into the UART.
- tx_busy  in  1  UART transmitter busy.
- sensor_data  in  8  live sensor value.
- alarm_in  in  1  alarm request, level.
- frames_sent  out  16  count of completed replies; wraps at 16'hFFFF.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: rx_rdy_clr=0, tx_wr_en=0, tx_din=8'h00, frames_sent=0, busy=0, alarm_pend=0, state=IDLE. Reset mid-frame aborts the frame; no partial byte is re-sent after reset.
- Alarm latch: alarm_pend is set on any cycle alarm_in=1 and is sticky. It clears only in the cycle the alarm frame's CRC byte is issued (tx_wr_en). If alarm_in is still 1 in that cycle, set wins.
- IDLE:
  - If rx_rdy=1, pulse rx_rdy_clr for 1 cycle.
  - If rx_dout[7:3]==0 and rx_dout[2:0]==SENSOR_ID, go to CAPTURE.
  - Otherwise stay in IDLE; the byte is dropped.
- CAPTURE (1 cycle):
  - data_reg <= alarm_pend ? ALARM_CODE : sensor_data.
  - is_alarm <= alarm_pend.
  - crc <= 0, bitcnt <= 0.
  - Go to CRC_CALC.
- CRC_CALC (exactly 8 cycles):
  - Each cycle: fb = crc[7] ^ data_reg[7-bitcnt]; crc <= {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - After bitcnt=7, go to SEND_DATA.
  - If is_alarm, the final CRC is inverted (XOR 8'hFF) before transmission.
- SEND_DATA: wait for tx_busy=0; then tx_din <= data_reg, pulse tx_wr_en, go to WAIT_DATA.
- WAIT_DATA: wait one cycle for tx_busy to rise, then wait for tx_busy=0, then go to SEND_CRC.
- SEND_CRC: wait for tx_busy=0; then tx_din <= crc (final), pulse tx_wr_en, increment frames_sent, go to WAIT_CRC.
- WAIT_CRC: same rule as WAIT_DATA, then go to IDLE.
- rx_rdy while not IDLE: ignored and not cleared. It is serviced on return to IDLE (at most one queued byte).
- Latency: tx_wr_en for the data byte occurs no earlier than 10 cycles after the matching rx_rdy edge.
- tx_wr_en is never asserted while tx_busy=1.

Optional Feature:
- Macro: SENSOR_RESPONDER_FAULT_INJECT_EN.
- Defined: adds input port fault_inject (1 bit). If fault_inject=1 when the CRC byte is issued, CRC bit0 is flipped.
- Not defined: no port, no corruption logic; the CRC is always correct.

Decomposition:
- Shared package sensor_link_pkg holds:
  - state encoding localparams.
  - CRC_POLY and ALARM_CODE defaults.
  - SENSOR_ID_MIN=1 and SENSOR_ID_MAX=5.
  - The alarm-inversion constant 8'hFF.
- One sub-module, crc8_serial: start/bit inputs, 8-bit crc output, done flag.
- The FSM and the UART handshake stay in sensor_responder.

Test Plan:
- SENSOR_ID=1, rx byte 8'h01, sensor_data=8'h01 -> tx bytes 8'h01, 8'h07; frames_sent=1; rx_rdy_clr pulsed once.
- rx byte 8'h02, then 8'h09 (bit3 set) -> both cleared; no tx_wr_en; frames_sent unchanged.
- alarm_in pulsed 1 cycle, then rx byte 8'h01 -> tx 8'hAA, 8'hA0; next poll with sensor_data=8'h80 -> tx 8'h80, 8'h89.
- tx_busy held high for 50 cycles after the data byte -> CRC byte issued only after tx_busy falls; no wr_en while busy.
- resetn low during CRC_CALC -> all outputs at reset values; next poll produces a correct complete frame.
- With SENSOR_RESPONDER_FAULT_INJECT_EN and fault_inject=1, sensor_data=8'h01 -> tx 8'h01, 8'h06.

Source files
------------

// File: rtl/sensor_link_pkg.sv
// sensor_link_pkg: shared state encoding, CRC/alarm constants and address helper for the sensor link
package sensor_link_pkg;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CAPTURE   = 3'd1;
  localparam logic [2:0] ST_CRC_CALC  = 3'd2;
  localparam logic [2:0] ST_SEND_DATA = 3'd3;
  localparam logic [2:0] ST_WAIT_DATA = 3'd4;
  localparam logic [2:0] ST_SEND_CRC  = 3'd5;
  localparam logic [2:0] ST_WAIT_CRC  = 3'd6;
  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    CAPTURE   = ST_CAPTURE,
    CRC_CALC  = ST_CRC_CALC,
    SEND_DATA = ST_SEND_DATA,
    WAIT_DATA = ST_WAIT_DATA,
    SEND_CRC  = ST_SEND_CRC,
    WAIT_CRC  = ST_WAIT_CRC
  } state_t;
  localparam logic [7:0] CRC_POLY_DEF   = 8'h07;
  localparam logic [7:0] ALARM_CODE_DEF = 8'hAA;
  localparam logic [7:0] ALARM_INV      = 8'hFF;
  localparam int SENSOR_ID_MIN = 1;
  localparam int SENSOR_ID_MAX = 5;
  // A select byte addresses us only if its upper five bits are clear and the low three equal our ID
  function automatic logic id_match(input logic [7:0] b, input logic [2:0] id);
    return (b[7:3] == 5'd0) && (b[2:0] == id);
  endfunction
endpackage

// File: rtl/sensor_responder_if.sv
// sensor_responder_if: UART receive/transmit handshake between the responder and the UART core
interface sensor_responder_if;
  logic [7:0] rx_dout;
  logic       rx_rdy;
  logic       rx_rdy_clr;
  logic [7:0] tx_din;
  logic       tx_wr_en;
  logic       tx_busy;
  modport master (output rx_dout, rx_rdy, tx_busy, input rx_rdy_clr, tx_din, tx_wr_en);
  modport slave  (input rx_dout, rx_rdy, tx_busy, output rx_rdy_clr, tx_din, tx_wr_en);
endinterface

// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial MSB-first CRC-8 (init 0); done marks the cycle the eighth bit is absorbed
module crc8_serial
  import sensor_link_pkg::*;
#(
  parameter logic [7:0] POLY = CRC_POLY_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc,
  output logic [2:0] bit_idx,
  output logic       done
);
  assign done = en && (bit_idx == 3'd7);
  // Shift one message bit per enabled cycle; start reinitialises for a new byte
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      crc     <= 8'h00;
      bit_idx <= 3'd0;
    end else if (start) begin
      crc     <= 8'h00;
      bit_idx <= 3'd0;
    end else if (en) begin
      crc     <= {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? POLY : 8'h00);
      bit_idx <= bit_idx + 3'd1;
    end
  end
endmodule

// File: rtl/sensor_responder.sv
// sensor_responder: answers polls for SENSOR_ID with a data+CRC-8 frame, or an alarm frame when an alarm is pending
// Optional build macro SENSOR_RESPONDER_FAULT_INJECT_EN adds fault_inject, which flips CRC bit0 of the issued CRC byte.
module sensor_responder
  import sensor_link_pkg::*;
#(
  parameter logic [2:0] SENSOR_ID  = 3'd1,
  parameter logic [7:0] ALARM_CODE = ALARM_CODE_DEF,
  parameter logic [7:0] CRC_POLY   = CRC_POLY_DEF
) (
  input  logic                clock,
  input  logic                resetn,
  sensor_responder_if.slave   link,
  input  logic [7:0]          sensor_data,
  input  logic                alarm_in,
`ifdef SENSOR_RESPONDER_FAULT_INJECT_EN
  input  logic                fault_inject,
`endif
  output logic [15:0]         frames_sent,
  output logic                busy
);
  state_t     state, next;
  logic [7:0] data_reg, crc, crc_final;
  logic [2:0] bit_idx;
  logic       is_alarm, alarm_pend, armed, armed_nxt;
  logic       take, issue_data, issue_crc, crc_done, flip;
`ifdef SENSOR_RESPONDER_FAULT_INJECT_EN
  assign flip = fault_inject;
`else
  assign flip = 1'b0;
`endif
  // rx_rdy stays high for one cycle after our clear pulse, so the guard stops the same byte being taken twice
  assign take      = (state == IDLE) && link.rx_rdy && !link.rx_rdy_clr;
  assign busy      = (state != IDLE);
  assign crc_final = crc ^ (is_alarm ? ALARM_INV : 8'h00) ^ {7'd0, flip};
  crc8_serial #(.POLY(CRC_POLY)) u_crc (
    .clock   (clock),
    .resetn  (resetn),
    .start   (state == CAPTURE),
    .en      (state == CRC_CALC),
    .bit_in  (data_reg[~bit_idx]),
    .crc     (crc),
    .bit_idx (bit_idx),
    .done    (crc_done)
  );
  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next;
  end
  // Next state; WAIT states skip one cycle so the UART has time to raise tx_busy
  always_comb begin
    next       = state;
    armed_nxt  = 1'b0;
    issue_data = 1'b0;
    issue_crc  = 1'b0;
    case (state)
      IDLE:      next = (take && id_match(link.rx_dout, SENSOR_ID)) ? CAPTURE : IDLE;
      CAPTURE:   next = CRC_CALC;
      CRC_CALC:  next = crc_done ? SEND_DATA : CRC_CALC;
      SEND_DATA: begin
        issue_data = !link.tx_busy;
        next       = link.tx_busy ? SEND_DATA : WAIT_DATA;
      end
      WAIT_DATA: begin
        armed_nxt = !(armed && !link.tx_busy);
        next      = (armed && !link.tx_busy) ? SEND_CRC : WAIT_DATA;
      end
      SEND_CRC:  begin
        issue_crc = !link.tx_busy;
        next      = link.tx_busy ? SEND_CRC : WAIT_CRC;
      end
      WAIT_CRC:  begin
        armed_nxt = !(armed && !link.tx_busy);
        next      = (armed && !link.tx_busy) ? IDLE : WAIT_CRC;
      end
      default:   next = IDLE;
    endcase
  end
  // Registered UART strobes, captured sample, frame counter and sticky alarm latch (set beats clear)
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      link.rx_rdy_clr <= 1'b0;
      link.tx_wr_en   <= 1'b0;
      link.tx_din     <= 8'h00;
      frames_sent     <= 16'd0;
      armed           <= 1'b0;
      data_reg        <= 8'h00;
      is_alarm        <= 1'b0;
      alarm_pend      <= 1'b0;
    end else begin
      link.rx_rdy_clr <= take;
      link.tx_wr_en   <= issue_data || issue_crc;
      link.tx_din     <= issue_data ? data_reg : issue_crc ? crc_final : link.tx_din;
      frames_sent     <= frames_sent + {15'd0, issue_crc};
      armed           <= armed_nxt;
      data_reg        <= (state == CAPTURE) ? (alarm_pend ? ALARM_CODE : sensor_data) : data_reg;
      is_alarm        <= (state == CAPTURE) ? alarm_pend : is_alarm;
      alarm_pend      <= alarm_in || (alarm_pend && !(link.tx_wr_en && state == WAIT_CRC && is_alarm));
    end
  end
endmodule
